// File: rtl/io_periph_bus.sv
// I/O-region register file: decodes core requests into GPIO, a multi-CS SPI channel
// and a UART channel with a receive FIFO, using a three-state request handshake.
module io_periph_bus #(
  parameter int GPIO_W       = 5,
  parameter int NUM_CS       = 4,
  parameter int CS_W         = 3,
  parameter int RX_DEPTH     = 4,
  parameter bit SPI_BLOCKING = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_request,
  input  logic              is_write,
  input  logic [7:0]        address,
  input  logic [31:0]       write_value,
  output logic [31:0]       read_value,
  output logic              request_done,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_dir,
  output logic              spi_start,
  output logic [7:0]        spi_tx_byte,
  input  logic              spi_done,
  input  logic [7:0]        spi_rx_byte,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              uart_tx_start,
  output logic [7:0]        uart_tx_byte,
  input  logic              uart_tx_done,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_byte
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, PEND, DONE} state_e;

  state_e            state_q, state_d;
  logic [31:0]       read_value_q, read_value_d;
  logic              request_done_q, request_done_d;
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d, gpio_dir_q, gpio_dir_d;
  logic [GPIO_W-1:0] gpio_s1_q, gpio_s2_q;
  logic              spi_start_q, spi_start_d, spi_sticky_q, spi_sticky_d;
  logic [NUM_CS-1:0] spi_cs_n_q, spi_cs_n_d;
  logic [7:0]        spi_tx_q, spi_tx_d, spi_rx_q, spi_rx_d;
  logic              uart_start_q, uart_start_d, uart_sticky_q, uart_sticky_d;
  logic [7:0]        uart_tx_q, uart_tx_d;
  logic [7:0]        mem_q [RX_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;

  logic [PW-1:0]     level;
  logic              empty, full, push, pop, flush, acc_wr, acc_rd, spi_go, cs_ok;
  logic [CS_W-1:0]   cs_idx;
  logic [31:0]       rd_data;

  assign level  = wr_ptr_q - rd_ptr_q;
  assign empty  = (level == '0);
  assign full   = (level == PW'(RX_DEPTH));
  assign acc_wr = (state_q == IDLE) && start_request && is_write;
  assign acc_rd = (state_q == IDLE) && start_request && !is_write;

  always_comb begin
    state_d        = state_q;
    read_value_d   = read_value_q;
    request_done_d = request_done_q;
    gpio_out_d     = gpio_out_q;
    gpio_dir_d     = gpio_dir_q;
    spi_start_d    = spi_start_q;
    spi_sticky_d   = spi_sticky_q;
    spi_cs_n_d     = spi_cs_n_q;
    spi_tx_d       = spi_tx_q;
    spi_rx_d       = spi_rx_q;
    uart_start_d   = uart_start_q;
    uart_sticky_d  = uart_sticky_q;
    uart_tx_d      = uart_tx_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    ovf_d          = ovf_q;
    flush          = 1'b0;
    pop            = 1'b0;
    push           = 1'b0;
    spi_go         = 1'b0;
    rd_data        = '0;
    cs_idx         = write_value[CS_W:1];
    cs_ok          = int'(cs_idx) < NUM_CS;

    // Channel completions first so a same-cycle accepted start takes precedence.
    if (spi_done) begin
      spi_start_d  = 1'b0;
      spi_cs_n_d   = '1;
      spi_rx_d     = spi_rx_byte;
      spi_sticky_d = 1'b1;
    end
    if (uart_tx_done) begin
      uart_start_d  = 1'b0;
      uart_sticky_d = 1'b1;
    end

    if (acc_wr) begin
      case (address)
        8'h00: gpio_out_d = write_value[GPIO_W-1:0] & gpio_dir_q;
        8'h02: gpio_dir_d = write_value[GPIO_W-1:0];
        8'h04: if (write_value[0] && cs_ok && !spi_start_q) begin
          spi_go       = 1'b1;
          spi_start_d  = 1'b1;
          spi_cs_n_d   = ~(NUM_CS'(1) << cs_idx);
          spi_sticky_d = 1'b0;
        end
        8'h05: spi_tx_d = write_value[7:0];
        8'h08: begin
          if (write_value[0] && !uart_start_q) begin
            uart_start_d  = 1'b1;
            uart_sticky_d = 1'b0;
          end
          flush = write_value[1];
          if (write_value[2]) ovf_d = 1'b0;
        end
        8'h09: uart_tx_d = write_value[7:0];
        default: ;
      endcase
    end

    case (address)
      8'h00: rd_data[GPIO_W-1:0] = gpio_out_q;
      8'h01: rd_data[GPIO_W-1:0] = gpio_s2_q & ~gpio_dir_q;
      8'h02: rd_data[GPIO_W-1:0] = gpio_dir_q;
      8'h04: rd_data[1:0] = {spi_sticky_q, spi_start_q};
      8'h05: rd_data[7:0] = spi_tx_q;
      8'h06: rd_data[7:0] = spi_rx_q;
      8'h08: rd_data[4:0] = {ovf_q, full, !empty, uart_sticky_q, uart_start_q};
      8'h09: rd_data[7:0] = uart_tx_q;
      8'h0A: if (!empty) begin
        rd_data[7:0] = mem_q[rd_ptr_q[AW-1:0]];
        pop          = acc_rd;
      end
      8'h0B: rd_data[PW-1:0] = level;
      default: ;
    endcase

    // A pop frees the slot a same-cycle push needs, so only push-without-pop overflows.
    if (uart_rx_valid && !flush) begin
      if (full && !pop) ovf_d = 1'b1;
      else              push  = 1'b1;
    end
    if (flush)    rd_ptr_d = wr_ptr_q;
    else if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push)     wr_ptr_d = wr_ptr_q + PW'(1);

    case (state_q)
      IDLE: if (start_request) begin
        read_value_d = is_write ? '0 : rd_data;
        if (spi_go && SPI_BLOCKING) begin
          state_d = PEND;
        end else begin
          state_d        = DONE;
          request_done_d = 1'b1;
        end
      end
      PEND: begin
        if (!start_request) begin
          state_d = IDLE;
        end else if (spi_done) begin
          state_d        = DONE;
          request_done_d = 1'b1;
        end
      end
      DONE: if (!start_request) begin
        state_d        = IDLE;
        request_done_d = 1'b0;
        read_value_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      read_value_q   <= '0;
      request_done_q <= 1'b0;
      gpio_out_q     <= '0;
      gpio_dir_q     <= '0;
      gpio_s1_q      <= '0;
      gpio_s2_q      <= '0;
      spi_start_q    <= 1'b0;
      spi_sticky_q   <= 1'b0;
      spi_cs_n_q     <= '1;
      spi_tx_q       <= '0;
      spi_rx_q       <= '0;
      uart_start_q   <= 1'b0;
      uart_sticky_q  <= 1'b0;
      uart_tx_q      <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      ovf_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      read_value_q   <= read_value_d;
      request_done_q <= request_done_d;
      gpio_out_q     <= gpio_out_d;
      gpio_dir_q     <= gpio_dir_d;
      gpio_s1_q      <= gpio_in;
      gpio_s2_q      <= gpio_s1_q;
      spi_start_q    <= spi_start_d;
      spi_sticky_q   <= spi_sticky_d;
      spi_cs_n_q     <= spi_cs_n_d;
      spi_tx_q       <= spi_tx_d;
      spi_rx_q       <= spi_rx_d;
      uart_start_q   <= uart_start_d;
      uart_sticky_q  <= uart_sticky_d;
      uart_tx_q      <= uart_tx_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      ovf_q          <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= uart_rx_byte;
  end

  assign read_value    = read_value_q;
  assign request_done  = request_done_q;
  assign gpio_out      = gpio_out_q;
  assign gpio_dir      = gpio_dir_q;
  assign spi_start     = spi_start_q;
  assign spi_tx_byte   = spi_tx_q;
  assign spi_cs_n      = spi_cs_n_q;
  assign uart_tx_start = uart_start_q;
  assign uart_tx_byte  = uart_tx_q;
endmodule

// File: tb/tb_io_periph_bus.sv
// Scoreboard bench for io_periph_bus: a register-level reference model predicts each
// read, a monitor compares on every request_done rising edge.
module tb_io_periph_bus;
  localparam int RX_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_request = 1'b0, is_write = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [31:0] write_value = 32'h0;
  logic [31:0] read_value;
  logic        request_done;
  logic [4:0]  gpio_in = 5'h0, gpio_out, gpio_dir;
  logic        spi_start, spi_done = 1'b0;
  logic [7:0]  spi_tx_byte, spi_rx_byte = 8'h00;
  logic [3:0]  spi_cs_n;
  logic        uart_tx_start, uart_tx_done = 1'b0, uart_rx_valid = 1'b0;
  logic [7:0]  uart_tx_byte, uart_rx_byte = 8'h00;

  io_periph_bus dut (
    .clk(clk), .rst_n(rst_n), .start_request(start_request), .is_write(is_write),
    .address(address), .write_value(write_value), .read_value(read_value),
    .request_done(request_done), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_dir(gpio_dir), .spi_start(spi_start), .spi_tx_byte(spi_tx_byte),
    .spi_done(spi_done), .spi_rx_byte(spi_rx_byte), .spi_cs_n(spi_cs_n),
    .uart_tx_start(uart_tx_start), .uart_tx_byte(uart_tx_byte),
    .uart_tx_done(uart_tx_done), .uart_rx_valid(uart_rx_valid),
    .uart_rx_byte(uart_rx_byte)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { bit chk; logic [7:0] a; logic [31:0] v; } exp_t;
  exp_t exp_q[$];

  // Reference model state
  logic [4:0] m_out, m_dir, m_gin;
  bit         m_spi_busy, m_spi_st, m_tx_busy, m_tx_st, m_ovf;
  logic [7:0] m_spi_rx, m_spi_tx, m_tx;
  logic [3:0] m_cs;
  logic [7:0] m_fifo[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_out = '0; m_dir = '0; m_spi_busy = 0; m_spi_st = 0; m_tx_busy = 0; m_tx_st = 0;
    m_ovf = 0; m_spi_rx = '0; m_spi_tx = '0; m_tx = '0; m_cs = 4'hF; m_fifo.delete();
  endfunction

  function automatic void m_push(input logic [7:0] b);
    if (m_fifo.size() >= RX_DEPTH) m_ovf = 1;
    else m_fifo.push_back(b);
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      8'h00: r = {27'd0, m_out};
      8'h01: r = {27'd0, m_gin & ~m_dir};
      8'h02: r = {27'd0, m_dir};
      8'h04: r = {30'd0, m_spi_st, m_spi_busy};
      8'h05: r = {24'd0, m_spi_tx};
      8'h06: r = {24'd0, m_spi_rx};
      8'h08: r = {27'd0, m_ovf, m_fifo.size() == RX_DEPTH, m_fifo.size() != 0, m_tx_st, m_tx_busy};
      8'h09: r = {24'd0, m_tx};
      8'h0A: if (m_fifo.size() != 0) r = {24'd0, m_fifo.pop_front()};
      8'h0B: r = 32'(m_fifo.size());
      default: r = '0;
    endcase
    return r;
  endfunction

  // Returns 1 when the write is an accepted SPI start that holds the request.
  function automatic bit m_write(input logic [7:0] a, input logic [31:0] d);
    case (a)
      8'h00: m_out = d[4:0] & m_dir;
      8'h02: m_dir = d[4:0];
      8'h04: if (d[0] && d[3:1] < 3'd4 && !m_spi_busy) begin
        m_spi_busy = 1; m_spi_st = 0; m_cs = ~(4'b0001 << d[3:1]);
        return 1'b1;
      end
      8'h05: m_spi_tx = d[7:0];
      8'h08: begin
        if (d[0] && !m_tx_busy) begin m_tx_busy = 1; m_tx_st = 0; end
        if (d[1]) m_fifo.delete();
        if (d[2]) m_ovf = 0;
      end
      8'h09: m_tx = d[7:0];
      default: ;
    endcase
    return 1'b0;
  endfunction

  task automatic pins();
    chk("gpio_out", 32'(gpio_out), 32'(m_out));
    chk("gpio_dir", 32'(gpio_dir), 32'(m_dir));
    chk("spi_start", 32'(spi_start), 32'(m_spi_busy));
    chk("spi_cs_n", 32'(spi_cs_n), 32'(m_cs));
    chk("spi_tx_byte", 32'(spi_tx_byte), 32'(m_spi_tx));
    chk("uart_tx_start", 32'(uart_tx_start), 32'(m_tx_busy));
    chk("uart_tx_byte", 32'(uart_tx_byte), 32'(m_tx));
  endtask

  task automatic bus(input bit w, input logic [7:0] a, input logic [31:0] d,
                     input bit rxv, input logic [7:0] rxb, input logic [7:0] sb);
    exp_t e;
    bit   pend;
    int   cyc;
    e.chk = !w; e.a = a; e.v = '0; pend = 0;
    if (w) pend = m_write(a, d);
    else   e.v = m_read(a);
    if (rxv && !(w && a == 8'h08 && d[1])) m_push(rxb);
    exp_q.push_back(e);
    @(posedge clk); #1;
    start_request = 1'b1; is_write = w; address = a; write_value = d;
    if (rxv) begin uart_rx_valid = 1'b1; uart_rx_byte = rxb; end
    cyc = 0;
    if (pend) begin
      repeat ($urandom_range(2, 5)) begin @(posedge clk); #1; end
      chk("pend_done_low", 32'(request_done), 32'd0);
      chk("pend_spi_start", 32'(spi_start), 32'd1);
      chk("pend_cs_n", 32'(spi_cs_n), 32'(m_cs));
      spi_done = 1'b1; spi_rx_byte = sb;
      @(posedge clk); #1;
      spi_done = 1'b0;
      m_spi_busy = 0; m_spi_st = 1; m_spi_rx = sb; m_cs = 4'hF;
      chk("pend_to_done", 32'(request_done), 32'd1);
    end else begin
      while (!request_done && cyc < 100) begin
        @(posedge clk); #1;
        uart_rx_valid = 1'b0;
        cyc++;
      end
      chk("latency", 32'(cyc), 32'd1);
    end
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
    start_request = 1'b0; is_write = 1'b0; address = 8'h00; write_value = '0;
    @(posedge clk); #1;
    chk("done_drop", 32'(request_done), 32'd0);
    pins();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic rd(input logic [7:0] a);
    bus(1'b0, a, 32'h0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(posedge clk); #1;
    uart_rx_valid = 1'b1; uart_rx_byte = b;
    @(posedge clk); #1;
    uart_rx_valid = 1'b0;
    m_push(b);
  endtask

  task automatic tx_done();
    @(posedge clk); #1;
    uart_tx_done = 1'b1;
    @(posedge clk); #1;
    uart_tx_done = 1'b0;
    m_tx_busy = 0; m_tx_st = 1;
    chk("tx_done_drop", 32'(uart_tx_start), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_read_value", read_value, 32'd0);
    chk("rst_request_done", 32'(request_done), 32'd0);
    chk("rst_gpio_out", 32'(gpio_out), 32'd0);
    chk("rst_gpio_dir", 32'(gpio_dir), 32'd0);
    chk("rst_spi_start", 32'(spi_start), 32'd0);
    chk("rst_spi_tx_byte", 32'(spi_tx_byte), 32'd0);
    chk("rst_spi_cs_n", 32'(spi_cs_n), 32'hF);
    chk("rst_uart_tx_start", 32'(uart_tx_start), 32'd0);
    chk("rst_uart_tx_byte", 32'(uart_tx_byte), 32'd0);
  endtask

  // Monitor: one expectation per completed request.
  initial begin
    exp_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (request_done && !prev) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: request_done rose with no request outstanding");
        end else begin
          e = exp_q.pop_front();
          if (e.chk) chk($sformatf("read_0x%0h", e.a), read_value, e.v);
        end
      end
      prev = request_done;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] raddr [12] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h05, 8'h06,
                             8'h08, 8'h09, 8'h0A, 8'h0B, 8'h03, 8'h07};

  initial begin
    logic [2:0] idx;
    m_reset();
    m_gin = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;

    // GPIO masking and input sync
    wr(8'h02, 32'h03);
    wr(8'h00, 32'h1F);
    chk("gpio_masked", 32'(gpio_out), 32'h03);
    @(posedge clk); #1;
    gpio_in = 5'h1C; m_gin = 5'h1C;
    repeat (3) @(posedge clk);
    rd(8'h01);

    // Blocking SPI to CS 2, then invalid index
    wr(8'h05, 32'hA5);
    bus(1'b1, 8'h04, 32'h05, 1'b0, 8'h00, 8'h3C);
    rd(8'h06);
    rd(8'h04);
    wr(8'h04, 32'h09);
    chk("spi_bad_idx_cs", 32'(spi_cs_n), 32'hF);

    // FIFO fill, overflow, drain, empty pop
    for (int i = 0; i < 5; i++) rx_push(8'h11 + 8'(i));
    rd(8'h0B);
    rd(8'h08);
    for (int i = 0; i < 5; i++) rd(8'h0A);
    rd(8'h0B);
    // Full with simultaneous push and pop, then flush with simultaneous push
    wr(8'h08, 32'h04);
    for (int i = 0; i < 4; i++) rx_push(8'h40 + 8'(i));
    bus(1'b0, 8'h0A, 32'h0, 1'b1, 8'h99, 8'h00);
    rd(8'h0B);
    rd(8'h08);
    bus(1'b1, 8'h08, 32'h02, 1'b1, 8'h77, 8'h00);
    rd(8'h0B);

    // UART TX
    wr(8'h09, 32'h55);
    wr(8'h08, 32'h01);
    wr(8'h09, 32'h66);
    wr(8'h08, 32'h01);
    tx_done();
    rd(8'h08);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 10))
        0: wr(8'h02, $urandom);
        1: wr(8'h00, $urandom);
        2: if ($urandom_range(0, 4) == 0) rd(8'($urandom_range(12, 255)));
           else rd(raddr[$urandom_range(0, 11)]);
        3: rx_push(8'($urandom));
        4: rd(8'h0A);
        5: begin
          @(posedge clk); #1;
          gpio_in = 5'($urandom); m_gin = gpio_in;
          repeat (3) @(posedge clk);
        end
        6: wr(8'h08, 32'($urandom_range(0, 7)));
        7: if (m_tx_busy) tx_done();
        8: wr(8'($urandom_range(12, 255)), $urandom);
        9: begin
          idx = 3'($urandom_range(0, 7));
          bus(1'b1, 8'h04, {28'd0, idx, 1'b1}, 1'b0, 8'h00, 8'($urandom));
        end
        default: wr($urandom_range(0, 1) == 0 ? 8'h05 : 8'h09, $urandom);
      endcase
    end

    // Reset while a blocking SPI request is pending and the FIFO holds two bytes
    wr(8'h08, 32'h02);
    rx_push(8'hA1);
    rx_push(8'hA2);
    rd(8'h0B);
    @(posedge clk); #1;
    start_request = 1'b1; is_write = 1'b1; address = 8'h04; write_value = 32'h03;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_spi_start", 32'(spi_start), 32'd1);
    chk("pre_rst_cs_n", 32'(spi_cs_n), 32'hD);
    chk("pre_rst_done", 32'(request_done), 32'd0);
    rst_n = 1'b0; start_request = 1'b0; is_write = 1'b0; address = 8'h00; write_value = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;
    m_reset();
    rd(8'h0B);
    rd(8'h08);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
